// File: rtl/fp_dispatcher.sv
// fp_dispatcher: requester side of the FPU start/finish four-phase handshake, one operation in flight.
// Optional ISSUE-phase abort is compiled in when FP_DISP_TIMEOUT_EN is defined.
module fp_dispatcher #(
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic             fpu_multiplicando,
    output logic             fpu_start,
    input  logic [31:0]      fpu_s,
    input  logic             fpu_finish,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

    state_t           state_reg;
    logic [TAG_W-1:0] tag_reg;

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

`ifdef FP_DISP_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    // Abort on the edge where the count would reach TIMEOUT_CYC, i.e. after TIMEOUT_CYC ISSUE cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;
    assign rsp_err = err_reg;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            tag_reg           <= '0;
            fpu_a             <= '0;
            fpu_b             <= '0;
            fpu_multiplicando <= 1'b0;
            fpu_start         <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_data          <= '0;
            rsp_tag           <= '0;
`ifdef FP_DISP_TIMEOUT_EN
            cnt_reg           <= '0;
            err_reg           <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        fpu_a             <= req_a;
                        fpu_b             <= req_b;
                        fpu_multiplicando <= req_op;
                        tag_reg           <= req_tag;
                        fpu_start         <= 1'b1;
`ifdef FP_DISP_TIMEOUT_EN
                        cnt_reg           <= '0;
`endif
                        state_reg         <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Completion has priority over a timeout landing on the same edge.
                    if (fpu_finish) begin
                        rsp_data  <= fpu_s;
                        fpu_start <= 1'b0;
`ifdef FP_DISP_TIMEOUT_EN
                        err_reg   <= 1'b0;
`endif
                        state_reg <= RELEASE;
                    end
`ifdef FP_DISP_TIMEOUT_EN
                    else if (cnt_reg == CNT_LAST) begin
                        rsp_data  <= 32'h7FC0_0000;
                        fpu_start <= 1'b0;
                        err_reg   <= 1'b1;
                        state_reg <= RELEASE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
`endif
                end
                RELEASE: begin
                    // Hold here until the FPU drops finish so the next start cannot alias it.
                    if (!fpu_finish) begin
                        rsp_valid <= 1'b1;
                        rsp_tag   <= tag_reg;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_dispatcher.sv
// Self-checking bench for fp_dispatcher: table vectors, hand-written corner sequences and random traffic.
`timescale 1ns/1ps
module tb_fp_dispatcher;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_op = 1'b0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      fpu_a, fpu_b;
    logic             fpu_multiplicando, fpu_start;
    logic [31:0]      fpu_s = '0;
    logic             fpu_finish = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    fp_dispatcher #(.TAG_W(TAG_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_multiplicando(fpu_multiplicando),
        .fpu_start(fpu_start), .fpu_s(fpu_s), .fpu_finish(fpu_finish),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        int               lat;
        int               hold;
        logic [31:0]      exp_data;
        logic [TAG_W-1:0] exp_tag;
        logic             exp_err;
    } vec_t;

    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
        logic             e;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stand-in FPU arithmetic: exact answers for the reference operands, a bit mix otherwise.
    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == 32'h3E80_0000 && b == 32'h3F00_0000)
            return op ? 32'h3E00_0000 : 32'h3F40_0000;
        return a ^ {b[15:0], b[31:16]} ^ {32{op}};
    endfunction

    // FPU responder: finish after fpu_lat cycles of start, drop it fpu_hold cycles after start falls.
    int fpu_lat = 5;
    int fpu_hold = 0;
    bit fpu_never = 1'b0;
    int fcnt = 0;
    always @(negedge clk) begin
        if (fpu_start && !fpu_finish) begin
            if (!fpu_never && fcnt >= fpu_lat - 1) begin
                fpu_finish = 1'b1;
                fpu_s = fpu_model(fpu_a, fpu_b, fpu_multiplicando);
                fcnt = 0;
            end else begin
                fcnt++;
            end
        end else if (!fpu_start && fpu_finish) begin
            if (fcnt >= fpu_hold) begin
                fpu_finish = 1'b0;
                fcnt = 0;
            end else begin
                fcnt++;
            end
        end else begin
            fcnt = 0;
        end
    end

    // Response consumer: 0 = always ready, 1 = stalled, 2 = random.
    int rr_mode = 0;
    always @(negedge clk) begin
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Handshake-ordering checker and response scoreboard.
    bit   skip_proto = 1'b0;
    logic p_start = 1'b0, p_fin = 1'b0, p_rv = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!skip_proto) begin
            if (fpu_start && !p_start) chk("start_rise_needs_finish_low", 32'(p_fin), 32'd0);
`ifndef FP_DISP_TIMEOUT_EN
            if (!fpu_start && p_start) chk("start_fall_needs_finish_high", 32'(p_fin), 32'd1);
`endif
            if (rsp_valid && !p_rv) chk("rsp_valid_needs_finish_low", 32'(p_fin), 32'd0);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got tag=%0d data=%h required none", rsp_tag, rsp_data);
            end else begin
                e = sb.pop_front();
                $display("rsp tag=%0d data=%h err=%0d (want tag=%0d data=%h err=%0d)",
                         rsp_tag, rsp_data, rsp_err, e.t, e.d, e.e);
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_tag", 32'(rsp_tag), 32'(e.t));
                chk("rsp_err", 32'(rsp_err), 32'(e.e));
            end
        end
        p_start = fpu_start;
        p_fin   = fpu_finish;
        p_rv    = rsp_valid;
    end

    // Present one request, wait (bounded) for acceptance, then check the FPU-side drive.
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] ed,
                        input logic [TAG_W-1:0] et, input logic ee, input bit push);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        while (!req_ready) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                chk("req_accept_timeout", 32'(n), 32'd0);
                req_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (push) sb.push_back('{ed, et, ee});
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("fpu_start_after_accept", 32'(fpu_start), 32'd1);
        chk("fpu_a", fpu_a, a);
        chk("fpu_b", fpu_b, b);
        chk("fpu_multiplicando", 32'(fpu_multiplicando), 32'(op));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 || busy) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                chk("drain_timeout", 32'(sb.size()), 32'd0);
                return;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        logic [31:0] ra, rb;
        logic        rop;
        logic [TAG_W-1:0] rtag;
        int n;

        tbl[0] = '{1'b0, 32'h3E80_0000, 32'h3F00_0000, 4'd3,  5, 0, 32'h3F40_0000, 4'd3,  1'b0};
        tbl[1] = '{1'b1, 32'h3E80_0000, 32'h3F00_0000, 4'd7,  5, 0, 32'h3E00_0000, 4'd7,  1'b0};
        tbl[2] = '{1'b0, 32'h4040_0000, 32'hC000_0000, 4'd15, 1, 4, 32'h4040_C000, 4'd15, 1'b0};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0001_0000, 4'd0,  2, 1, 32'h0000_0001, 4'd0,  1'b0};
        tbl[4] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 4'd10, 3, 2, 32'hCCC4_CCC4, 4'd10, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("reset_fpu_start", 32'(fpu_start), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_fpu_a", fpu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single operations
        rr_mode = 0;
        for (int i = 0; i < 5; i++) begin
            fpu_lat  = tbl[i].lat;
            fpu_hold = tbl[i].hold;
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag,
                 tbl[i].exp_data, tbl[i].exp_tag, tbl[i].exp_err, 1'b1);
            wait_drain();
        end

        // Backpressure: response held stable, requests refused
        rr_mode  = 1;
        fpu_lat  = 3;
        fpu_hold = 0;
        send(1'b0, 32'h3F80_0000, 32'h3F80_0000, 4'd5, 32'h3F80_3F80, 4'd5, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_tag   = 4'd9;
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", rsp_data, 32'h3F80_3F80);
            chk("bp_rsp_tag", 32'(rsp_tag), 32'd5);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rr_mode   = 0;
        wait_drain();

        // Reset while ISSUE is in progress
        fpu_lat = 50;
        send(1'b1, 32'h4000_0000, 32'h4040_0000, 4'd6, 32'd0, 4'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        skip_proto = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_fpu_start", 32'(fpu_start), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_no_response", 32'(rsp_valid), 32'd0);
        skip_proto = 1'b0;
        fpu_lat = 4;
        send(1'b0, 32'h4000_0000, 32'h4040_0000, 4'd8, 32'h4000_4040, 4'd8, 1'b0, 1'b1);
        wait_drain();

        // Back-to-back queued requests
        fpu_lat  = 2;
        fpu_hold = 2;
        send(1'b0, 32'h1111_1111, 32'h2222_2222, 4'd1, 32'h3333_3333, 4'd1, 1'b0, 1'b1);
        send(1'b1, 32'h3333_3333, 32'h4444_4444, 4'd2, 32'h8888_8888, 4'd2, 1'b0, 1'b1);
        wait_drain();

        // Random traffic with random FPU timing and consumer stalls
        rr_mode = 2;
        for (int i = 0; i < 24; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rop  = 1'($urandom_range(0, 1));
            rtag = TAG_W'($urandom_range(0, 15));
            fpu_lat  = $urandom_range(1, 6);
            fpu_hold = $urandom_range(0, 3);
            send(rop, ra, rb, rtag, fpu_model(ra, rb, rop), rtag, 1'b0, 1'b1);
        end
        wait_drain();
        rr_mode = 0;

`ifdef FP_DISP_TIMEOUT_EN
        // FPU never answers: abort after 16 ISSUE cycles
        fpu_never = 1'b1;
        send(1'b0, 32'h3F80_0000, 32'h4000_0000, 4'd12, 32'h7FC0_0000, 4'd12, 1'b1, 1'b1);
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            #1;
            if (!fpu_start) break;
            n++;
        end
        chk("timeout_issue_cycles", 32'(n), 32'd16);
        fpu_never = 1'b0;
        wait_drain();
        fpu_lat = 3;
        send(1'b1, 32'h3F80_0000, 32'h4000_0000, 4'd4, fpu_model(32'h3F80_0000, 32'h4000_0000, 1'b1),
             4'd4, 1'b0, 1'b1);
        wait_drain();
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
